// File: rtl/match_pkg.sv
// Shared encodings and widths for the round/match sequencer and its second counters.
package match_pkg;

   localparam int PHASE_W = 3;
   localparam int WIN_W   = 2;
   localparam int CD_W    = 2;
   localparam int TIME_W  = 7;

   typedef enum logic [PHASE_W-1:0] {
      PH_IDLE       = 3'd0,
      PH_COUNTDOWN  = 3'd1,
      PH_FIGHT      = 3'd2,
      PH_ROUND_END  = 3'd3,
      PH_MATCH_OVER = 3'd4
   } phase_t;

   typedef enum logic [WIN_W-1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_t;

   // Win counters stop at the match target so a stray extra win cannot wrap them.
   function automatic logic [WIN_W-1:0] satInc(input logic [WIN_W-1:0] value,
                                                input logic [WIN_W-1:0] limit);
      return (value >= limit) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/sec_counter.sv
// Frame-to-second prescaler: counts enabled frames and steps a loadable seconds value down.
module sec_counter #(
   parameter int FRAMES_PER_SEC = 30,
   parameter int VAL_W          = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [VAL_W-1:0] i_loadVal,
   input  logic             i_en,
   output logic [VAL_W-1:0] o_value,
   output logic             o_wrap
);

   localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_SEC - 1);

   logic [FRAME_W-1:0] r_frame;
   logic [VAL_W-1:0]   r_value;

   assign o_wrap  = i_en && (r_frame == LAST_FRAME);
   assign o_value = r_value;

   // Load wins over counting so a phase entry always starts from a clean second.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_frame <= '0;
         r_value <= '0;
      end else if (i_load) begin
         r_frame <= '0;
         r_value <= i_loadVal;
      end else if (i_en) begin
         if (r_frame == LAST_FRAME) begin
            r_frame <= '0;
            if (r_value != '0) begin
               r_value <= r_value - 1'b1;
            end
         end else begin
            r_frame <= r_frame + 1'b1;
         end
      end
   end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: freezes players, pulses round resets, tracks best-of-N wins.
// Defining FOOTIES_ROUND_TIMER_EN adds a round time limit decided on remaining health.
module match_controller
   import match_pkg::*;
#(
   parameter int FRAMES_PER_SEC   = 30,
   parameter int COUNTDOWN_SEC    = 3,
   parameter int ROUND_END_FRAMES = 60,
   parameter int ROUNDS_TO_WIN    = 2,
   parameter int ROUND_TIME_SEC   = 60
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_frame_tick,
   input  logic              i_start,
   input  logic              i_game_over1,
   input  logic              i_game_over2,
   input  logic [1:0]        i_health1,
   input  logic [1:0]        i_health2,
   output logic              o_play_en,
   output logic              o_round_rst,
   output logic [PHASE_W-1:0] o_phase,
   output logic [CD_W-1:0]   o_countdown,
   output logic [WIN_W-1:0]  o_p1_wins,
   output logic [WIN_W-1:0]  o_p2_wins,
   output logic [WIN_W-1:0]  o_round_winner,
   output logic [WIN_W-1:0]  o_match_winner,
   output logic [TIME_W-1:0] o_time_left
);

   localparam int END_W = (ROUND_END_FRAMES > 1) ? $clog2(ROUND_END_FRAMES) : 1;
   localparam logic [END_W-1:0] END_LAST    = END_W'(ROUND_END_FRAMES - 1);
   localparam logic [WIN_W-1:0] WINS_TARGET = WIN_W'(ROUNDS_TO_WIN);
   localparam logic [CD_W-1:0]  CD_LOAD     = CD_W'(COUNTDOWN_SEC);

   if (COUNTDOWN_SEC < 1 || COUNTDOWN_SEC > 3) begin : g_badCountdown
      $error("match_controller: COUNTDOWN_SEC must be 1..3");
   end
   if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 3) begin : g_badRounds
      $error("match_controller: ROUNDS_TO_WIN must be 1..3");
   end
   if (ROUND_TIME_SEC < 1 || ROUND_TIME_SEC > 99) begin : g_badTime
      $error("match_controller: ROUND_TIME_SEC must be 1..99");
   end

   phase_t            r_state, w_nextState;
   winner_t           r_roundWinner, w_roundWinner, r_matchWinner, w_matchWinner, w_healthWinner;
   logic [WIN_W-1:0]  r_p1Wins, w_p1Wins, r_p2Wins, w_p2Wins;
   logic [END_W-1:0]  r_endCnt;
   logic              r_playEn, r_roundRst;
   logic              w_enterCountdown, w_cdWrap, w_cdExpire, w_timeout;
   logic [CD_W-1:0]   w_cdValue;

   assign w_enterCountdown = (w_nextState == PH_COUNTDOWN) && (r_state != PH_COUNTDOWN);
   assign w_cdExpire       = w_cdWrap && (w_cdValue == CD_W'(1));

   sec_counter #(.FRAMES_PER_SEC(FRAMES_PER_SEC), .VAL_W(CD_W)) u_countdown (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_enterCountdown),
      .i_loadVal (CD_LOAD),
      .i_en      (i_frame_tick && (r_state == PH_COUNTDOWN)),
      .o_value   (w_cdValue),
      .o_wrap    (w_cdWrap)
   );

`ifdef FOOTIES_ROUND_TIMER_EN
   logic [TIME_W-1:0] w_timeValue;
   logic              w_timeWrap;

   sec_counter #(.FRAMES_PER_SEC(FRAMES_PER_SEC), .VAL_W(TIME_W)) u_roundTimer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_enterCountdown),
      .i_loadVal (TIME_W'(ROUND_TIME_SEC)),
      .i_en      (i_frame_tick && (r_state == PH_FIGHT)),
      .o_value   (w_timeValue),
      .o_wrap    (w_timeWrap)
   );

   assign w_timeout   = w_timeWrap && (w_timeValue == TIME_W'(1));
   assign o_time_left = w_timeValue;
`else
   assign w_timeout   = 1'b0;
   assign o_time_left = '0;
`endif

   always_comb begin
      w_healthWinner = WIN_NONE;
      if (i_health1 > i_health2) begin
         w_healthWinner = WIN_P1;
      end else if (i_health2 > i_health1) begin
         w_healthWinner = WIN_P2;
      end
   end

   // Next phase; game_over is watched every clock in FIGHT, everything else waits for ticks.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         PH_IDLE:       if (i_start) w_nextState = PH_COUNTDOWN;
         PH_COUNTDOWN:  if (w_cdExpire) w_nextState = PH_FIGHT;
         PH_FIGHT:      if (i_game_over1 || i_game_over2 || w_timeout) w_nextState = PH_ROUND_END;
         PH_ROUND_END: begin
            if (i_frame_tick && (r_endCnt == END_LAST)) begin
               if ((r_p1Wins == WINS_TARGET) || (r_p2Wins == WINS_TARGET)) begin
                  w_nextState = PH_MATCH_OVER;
               end else begin
                  w_nextState = PH_COUNTDOWN;
               end
            end
         end
         PH_MATCH_OVER: if (i_start) w_nextState = PH_COUNTDOWN;
         default:       w_nextState = PH_IDLE;
      endcase
   end

   // Score bookkeeping; a simultaneous knockout is a draw and overrides any timeout.
   always_comb begin
      w_p1Wins      = r_p1Wins;
      w_p2Wins      = r_p2Wins;
      w_roundWinner = r_roundWinner;
      w_matchWinner = r_matchWinner;
      case (r_state)
         PH_FIGHT: begin
            if (i_game_over1 && i_game_over2) begin
               w_roundWinner = WIN_NONE;
            end else if (i_game_over1) begin
               w_roundWinner = WIN_P2;
               w_p2Wins      = satInc(r_p2Wins, WINS_TARGET);
            end else if (i_game_over2) begin
               w_roundWinner = WIN_P1;
               w_p1Wins      = satInc(r_p1Wins, WINS_TARGET);
            end else if (w_timeout) begin
               w_roundWinner = w_healthWinner;
               if (w_healthWinner == WIN_P1) w_p1Wins = satInc(r_p1Wins, WINS_TARGET);
               if (w_healthWinner == WIN_P2) w_p2Wins = satInc(r_p2Wins, WINS_TARGET);
            end
         end
         PH_ROUND_END: begin
            if (w_nextState == PH_MATCH_OVER) begin
               w_matchWinner = (r_p1Wins == WINS_TARGET) ? WIN_P1 : WIN_P2;
            end
         end
         PH_MATCH_OVER: begin
            if (i_start) begin
               w_p1Wins      = '0;
               w_p2Wins      = '0;
               w_roundWinner = WIN_NONE;
               w_matchWinner = WIN_NONE;
            end
         end
         default: ;
      endcase
   end

   // All status outputs are registered here so displays never see comb glitches.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= PH_IDLE;
         r_p1Wins      <= '0;
         r_p2Wins      <= '0;
         r_roundWinner <= WIN_NONE;
         r_matchWinner <= WIN_NONE;
         r_playEn      <= 1'b0;
         r_roundRst    <= 1'b0;
         r_endCnt      <= '0;
      end else begin
         r_state       <= w_nextState;
         r_p1Wins      <= w_p1Wins;
         r_p2Wins      <= w_p2Wins;
         r_roundWinner <= w_roundWinner;
         r_matchWinner <= w_matchWinner;
         r_playEn      <= (w_nextState == PH_FIGHT);
         r_roundRst    <= w_enterCountdown;
         if (r_state != PH_ROUND_END) begin
            r_endCnt <= '0;
         end else if (i_frame_tick) begin
            r_endCnt <= r_endCnt + 1'b1;
         end
      end
   end

   assign o_phase        = r_state;
   assign o_play_en      = r_playEn;
   assign o_round_rst    = r_roundRst;
   assign o_countdown    = w_cdValue;
   assign o_p1_wins      = r_p1Wins;
   assign o_p2_wins      = r_p2Wins;
   assign o_round_winner = r_roundWinner;
   assign o_match_winner = r_matchWinner;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios plus random play against a frame-count model.
// Timer scenarios are included when FOOTIES_ROUND_TIMER_EN is defined.
module tb_match_controller;

   localparam int FPS = 4;
   localparam int CD  = 3;
   localparam int REF = 2;
   localparam int RTW = 2;
   localparam int RTS = 2;
`ifdef FOOTIES_ROUND_TIMER_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1, tick = 1'b1, start = 1'b0, g1 = 1'b0, g2 = 1'b0;
   logic [1:0] h1 = 2'd3, h2 = 2'd3;
   logic       play, rrst;
   logic [2:0] phase;
   logic [1:0] cd, p1w, p2w, rw, mw;
   logic [6:0] timeLeft;

   int nCompared = 0;
   int nMismatched = 0;

   // Model state: phase number, ticks spent in the current timed phase, fight ticks, scores.
   int mPhase = 0, mTicks = 0, mFT = 0, mTime = 0, mP1 = 0, mP2 = 0, mRW = 0, mMW = 0;
   bit mRst = 1'b0;

   match_controller #(
      .FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CD), .ROUND_END_FRAMES(REF),
      .ROUNDS_TO_WIN(RTW), .ROUND_TIME_SEC(RTS)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_frame_tick(tick), .i_start(start),
      .i_game_over1(g1), .i_game_over2(g2), .i_health1(h1), .i_health2(h2),
      .o_play_en(play), .o_round_rst(rrst), .o_phase(phase), .o_countdown(cd),
      .o_p1_wins(p1w), .o_p2_wins(p2w), .o_round_winner(rw), .o_match_winner(mw),
      .o_time_left(timeLeft)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic void enterCountdown();
      mPhase = 1; mTicks = 0; mRst = 1'b1; mFT = 0;
      mTime  = TIMER_ON ? RTS : 0;
   endfunction

   function automatic void endRound(input int w);
      mPhase = 3; mTicks = 0; mRW = w;
      if (w == 1 && mP1 < RTW) mP1++;
      if (w == 2 && mP2 < RTW) mP2++;
   endfunction

   // Predicts the registered outputs after the coming edge from the current inputs.
   function automatic void modelStep();
      bit expired;
      expired = 1'b0;
      mRst = 1'b0;
      if (reset) begin
         mPhase = 0; mTicks = 0; mFT = 0; mTime = 0;
         mP1 = 0; mP2 = 0; mRW = 0; mMW = 0;
         return;
      end
      case (mPhase)
         0: if (start) enterCountdown();
         1: if (tick) begin
               mTicks++;
               if (mTicks == CD * FPS) mPhase = 2;
            end
         2: begin
               if (TIMER_ON && tick) begin
                  mFT++;
                  mTime = RTS - mFT / FPS;
                  expired = (mFT == RTS * FPS);
               end
               if (g1 && g2)   endRound(0);
               else if (g1)    endRound(2);
               else if (g2)    endRound(1);
               else if (expired) endRound((h1 > h2) ? 1 : ((h2 > h1) ? 2 : 0));
            end
         3: if (tick) begin
               mTicks++;
               if (mTicks == REF) begin
                  if (mP1 == RTW || mP2 == RTW) begin
                     mPhase = 4;
                     mMW = (mP1 == RTW) ? 1 : 2;
                  end else begin
                     enterCountdown();
                  end
               end
            end
         4: if (start) begin
               mP1 = 0; mP2 = 0; mRW = 0; mMW = 0;
               enterCountdown();
            end
         default: mPhase = 0;
      endcase
   endfunction

   task automatic stepClk();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic waitPhase(input int target, input int budget);
      int n = 0;
      while (phase !== 3'(target) && n < budget) begin
         stepClk();
         n++;
      end
      nCompared++;
      if (phase !== 3'(target)) begin
         nMismatched++;
         $display("[TB] FAIL waitPhase: phase=%0d after %0d cycles, required %0d", phase, n, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stepClk();
      stepClk();
      reset = 1'b0;
      nCompared++;
      if ({phase, play, rrst, cd, p1w, p2w, rw, mw, timeLeft} !== 26'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset: outputs=%h required all zero",
                  {phase, play, rrst, cd, p1w, p2w, rw, mw, timeLeft});
      end
   endtask

   task automatic test_countdown();
      int expPhase, expCd;
      bit expRst, expPlay;
      start = 1'b1;
      stepClk();
      start = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         if (k > 1) stepClk();
         expPhase = (k == 13) ? 2 : 1;
         expCd    = (k == 13) ? 0 : CD - (k - 1) / FPS;
         expRst   = (k == 1);
         expPlay  = (k == 13);
         nCompared++;
         if ({phase, cd, rrst, play} !== {3'(expPhase), 2'(expCd), expRst, expPlay}) begin
            nMismatched++;
            $display("[TB] FAIL countdown cycle %0d: phase/cd/rst/play=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                     k, phase, cd, rrst, play, expPhase, expCd, expRst, expPlay);
         end
      end
   endtask

   task automatic test_p1_round_win();
      g2 = 1'b1;
      stepClk();
      g2 = 1'b0;
      nCompared++;
      if ({phase, p1w, rw, play} !== {3'd3, 2'd1, 2'b01, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL p1_round_win: phase/p1/rw/play=%0d/%0d/%0d/%0d required 3/1/1/0",
                  phase, p1w, rw, play);
      end
      stepClk();
      nCompared++;
      if (phase !== 3'd3) begin
         nMismatched++;
         $display("[TB] FAIL round_end_hold: phase=%0d required 3", phase);
      end
      stepClk();
      nCompared++;
      if ({phase, rrst} !== {3'd1, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL round_end_exit: phase/rst=%0d/%0d required 1/1", phase, rrst);
      end
      stepClk();
      nCompared++;
      if (rrst !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL round_rst_width: rst=%0d required 0", rrst);
      end
   endtask

   task automatic test_match_over();
      waitPhase(2, 20);
      g2 = 1'b1;
      stepClk();
      g2 = 1'b0;
      stepClk();
      stepClk();
      nCompared++;
      if ({phase, p1w, mw, play} !== {3'd4, 2'd2, 2'b01, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL match_over: phase/p1/mw/play=%0d/%0d/%0d/%0d required 4/2/1/0",
                  phase, p1w, mw, play);
      end
      for (int i = 0; i < 10; i++) begin
         g1 = 1'($urandom_range(0, 1));
         g2 = 1'($urandom_range(0, 1));
         stepClk();
         nCompared++;
         if ({phase, p1w, p2w, rw, mw, play, rrst, cd} !== {3'd4, 2'd2, 2'd0, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0}) begin
            nMismatched++;
            $display("[TB] FAIL match_over_hold %0d: outputs=%h required %h", i,
                     {phase, p1w, p2w, rw, mw, play, rrst, cd},
                     {3'd4, 2'd2, 2'd0, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0});
         end
      end
      g1 = 1'b0;
      g2 = 1'b0;
      start = 1'b1;
      stepClk();
      start = 1'b0;
      nCompared++;
      if ({phase, p1w, p2w, rw, mw, rrst} !== {3'd1, 2'd0, 2'd0, 2'b00, 2'b00, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL rematch: phase/p1/p2/rw/mw/rst=%0d/%0d/%0d/%0d/%0d/%0d required 1/0/0/0/0/1",
                  phase, p1w, p2w, rw, mw, rrst);
      end
   endtask

   task automatic test_draw();
      waitPhase(2, 20);
      g1 = 1'b1;
      g2 = 1'b1;
      stepClk();
      g1 = 1'b0;
      g2 = 1'b0;
      nCompared++;
      if ({phase, rw, p1w, p2w} !== {3'd3, 2'b00, 2'd0, 2'd0}) begin
         nMismatched++;
         $display("[TB] FAIL draw: phase/rw/p1/p2=%0d/%0d/%0d/%0d required 3/0/0/0", phase, rw, p1w, p2w);
      end
      waitPhase(1, 4);
   endtask

   task automatic test_reset_mid();
      repeat (3) stepClk();
      reset = 1'b1;
      stepClk();
      reset = 1'b0;
      nCompared++;
      if ({phase, play, rrst, cd, p1w, p2w, rw, mw, timeLeft} !== 26'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_mid_countdown: outputs=%h required all zero",
                  {phase, play, rrst, cd, p1w, p2w, rw, mw, timeLeft});
      end
      start = 1'b1;
      stepClk();
      start = 1'b0;
      waitPhase(2, 20);
      start = 1'b1;
      repeat (3) stepClk();
      start = 1'b0;
      nCompared++;
      if ({phase, play, rrst} !== {3'd2, 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL start_in_fight: phase/play/rst=%0d/%0d/%0d required 2/1/0", phase, play, rrst);
      end
      g1 = 1'b1;
      stepClk();
      g1 = 1'b0;
      nCompared++;
      if ({phase, p2w, rw} !== {3'd3, 2'd1, 2'b10}) begin
         nMismatched++;
         $display("[TB] FAIL p2_round_win: phase/p2/rw=%0d/%0d/%0d required 3/1/2", phase, p2w, rw);
      end
      reset = 1'b1;
      stepClk();
      reset = 1'b0;
      nCompared++;
      if ({phase, play, rrst, cd, p1w, p2w, rw, mw, timeLeft} !== 26'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_mid_round_end: outputs=%h required all zero",
                  {phase, play, rrst, cd, p1w, p2w, rw, mw, timeLeft});
      end
   endtask

`ifdef FOOTIES_ROUND_TIMER_EN
   task automatic test_timer();
      h1 = 2'd3;
      h2 = 2'd1;
      start = 1'b1;
      stepClk();
      start = 1'b0;
      waitPhase(2, 20);
      nCompared++;
      if (timeLeft !== 7'd2) begin
         nMismatched++;
         $display("[TB] FAIL timer_load: time_left=%0d required 2", timeLeft);
      end
      for (int k = 1; k <= 7; k++) stepClk();
      nCompared++;
      if ({phase, timeLeft} !== {3'd2, 7'd1}) begin
         nMismatched++;
         $display("[TB] FAIL timer_before_expiry: phase/time=%0d/%0d required 2/1", phase, timeLeft);
      end
      stepClk();
      nCompared++;
      if ({phase, p1w, rw, timeLeft} !== {3'd3, 2'd1, 2'b01, 7'd0}) begin
         nMismatched++;
         $display("[TB] FAIL timer_health_win: phase/p1/rw/time=%0d/%0d/%0d/%0d required 3/1/1/0",
                  phase, p1w, rw, timeLeft);
      end
      waitPhase(2, 30);
      h1 = 2'd2;
      h2 = 2'd2;
      repeat (8) stepClk();
      nCompared++;
      if ({phase, rw, p1w, p2w} !== {3'd3, 2'b00, 2'd1, 2'd0}) begin
         nMismatched++;
         $display("[TB] FAIL timer_draw: phase/rw/p1/p2=%0d/%0d/%0d/%0d required 3/0/1/0", phase, rw, p1w, p2w);
      end
      waitPhase(2, 30);
      h1 = 2'd3;
      h2 = 2'd1;
      repeat (7) stepClk();
      g1 = 1'b1;
      stepClk();
      g1 = 1'b0;
      nCompared++;
      if ({phase, rw, p1w, p2w} !== {3'd3, 2'b10, 2'd1, 2'd1}) begin
         nMismatched++;
         $display("[TB] FAIL timer_game_over_priority: phase/rw/p1/p2=%0d/%0d/%0d/%0d required 3/2/1/1",
                  phase, rw, p1w, p2w);
      end
      h1 = 2'd3;
      h2 = 2'd3;
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         tick  = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 5) == 0);
         g1    = ($urandom_range(0, 15) == 0);
         g2    = ($urandom_range(0, 15) == 0);
         h1    = 2'($urandom_range(0, 3));
         h2    = 2'($urandom_range(0, 3));
         stepClk();
         nCompared++;
         if ({phase, play, rrst, cd} !== {3'(mPhase), (mPhase == 2), mRst, 2'((mPhase == 1) ? CD - mTicks / FPS : 0)}) begin
            nMismatched++;
            $display("[TB] FAIL random phase %0d: phase/play/rst/cd=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                     n, phase, play, rrst, cd, mPhase, (mPhase == 2), mRst,
                     (mPhase == 1) ? CD - mTicks / FPS : 0);
         end
         nCompared++;
         if ({p1w, p2w, rw, mw} !== {2'(mP1), 2'(mP2), 2'(mRW), 2'(mMW)}) begin
            nMismatched++;
            $display("[TB] FAIL random score %0d: p1/p2/rw/mw=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                     n, p1w, p2w, rw, mw, mP1, mP2, mRW, mMW);
         end
         nCompared++;
         if (timeLeft !== 7'(mTime)) begin
            nMismatched++;
            $display("[TB] FAIL random time_left %0d: time_left=%0d required %0d", n, timeLeft, mTime);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      g1 = 1'b0;
      g2 = 1'b0;
      tick = 1'b1;
   endtask

   initial begin
      $display("[TB] match_controller bench start (timer %0d)", TIMER_ON);
      test_reset();
      test_countdown();
      test_p1_round_win();
      test_match_over();
      test_draw();
      test_reset_mid();
`ifdef FOOTIES_ROUND_TIMER_EN
      test_timer();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer for the fighting game.
- Freezes or unfreezes player FSMs and re-arms health between rounds.
- Counts round wins (best-of-N) and declares the match winner.
- Sits between the frame-clock selection and the fsm / health_logic / hitlogic instances; its outputs also drive the HEX/LED status displays.

Parameters:
- FRAMES_PER_SEC, 30, frame_tick pulses per displayed second.
- COUNTDOWN_SEC, 3, pre-fight countdown length in seconds; legal range 1..3.
- ROUND_END_FRAMES, 60, frame_ticks held in ROUND_END before the next phase.
- ROUNDS_TO_WIN, 2, round wins needed to take the match; legal range 1..3.
- ROUND_TIME_SEC, 60, round time limit in seconds; used only with ROUND_TIMER_EN; legal range 1..99.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle game-frame enable; all timing advances only on it.
- start  in  1  level, debounced start request.
- game_over1  in  1  player 1 health exhausted.
- game_over2  in  1  player 2 health exhausted.
- health1  in  2  player 1 health.
- health2  in  2  player 2 health.
- play_en  out  1  high only in FIGHT; gates player FSM movement and attacks.
- round_rst  out  1  one-cycle pulse; OR'd into the fsm and health_logic resets.
- phase  out  3  IDLE=0, COUNTDOWN=1, FIGHT=2, ROUND_END=3, MATCH_OVER=4.
- countdown  out  2  seconds remaining in COUNTDOWN; 0 otherwise.
- p1_wins  out  2  rounds won by player 1.
- p2_wins  out  2  rounds won by player 2.
- round_winner  out  2  00 none/draw, 01 P1, 10 P2; latched at ROUND_END entry.
- match_winner  out  2  00 none, 01 P1, 10 P2.
- time_left  out  7  seconds left in the round (feature only; 0 otherwise).

Behaviour:
- Reset values: phase=IDLE; all outputs 0; internal frame and second counters 0. Reset mid-operation returns to IDLE on the next edge.
- All outputs are registered; phase changes are visible the cycle after the deciding edge.
- IDLE: start=1 -> COUNTDOWN. The transition does not wait for frame_tick.
- Every entry into COUNTDOWN:
  - round_rst=1 for exactly one cycle (the first COUNTDOWN cycle);
  - frame counter cleared;
  - countdown=COUNTDOWN_SEC.
- COUNTDOWN: countdown decrements every FRAMES_PER_SEC ticks. On the tick completing COUNTDOWN_SEC*FRAMES_PER_SEC ticks -> FIGHT, with countdown=0.
- FIGHT: play_en=1. game_over1/game_over2 are sampled on every clk, not only on ticks.
  - game_over1 only -> ROUND_END; p2_wins+1; round_winner=10.
  - game_over2 only -> ROUND_END; p1_wins+1; round_winner=01.
  - both in the same cycle -> ROUND_END as a draw; no win counted; round_winner=00.
- game_over inputs are ignored outside FIGHT. Stale game_over in COUNTDOWN is harmless because round_rst clears health.
- ROUND_END: play_en=0. After ROUND_END_FRAMES ticks:
  - if p1_wins or p2_wins == ROUNDS_TO_WIN -> MATCH_OVER, with match_winner set;
  - else -> COUNTDOWN.
- Win counters saturate at ROUNDS_TO_WIN.
- MATCH_OVER: holds indefinitely. start=1 -> counters, round_winner and match_winner cleared; -> COUNTDOWN with a round_rst pulse.
- start is ignored in COUNTDOWN, FIGHT and ROUND_END.
- frame_tick held permanently high (manual step mode) is legal; every clk then counts as one frame.

Optional Feature:
- Macro: FOOTIES_ROUND_TIMER_EN.
- Defined:
  - time_left loads ROUND_TIME_SEC on COUNTDOWN entry.
  - It decrements every FRAMES_PER_SEC ticks while in FIGHT.
  - Reaching 0 in FIGHT -> ROUND_END; the higher health wins the round, equal health is a draw.
  - game_over in the same cycle as expiry takes priority over the timeout.
- Undefined: time_left tied to 0; no timeout; rounds end only on game_over.

Decomposition:
- Shared package match_pkg holds:
  - phase encodings (PH_IDLE..PH_MATCH_OVER);
  - winner codes (WIN_NONE, WIN_P1, WIN_P2);
  - counter width constants.
- One sub-module, sec_counter: frame-to-second prescaler with load, enable, wrap pulse and down-counting value. It is instantiated for the countdown and, under the macro, for the round timer.

Test Plan (overrides FRAMES_PER_SEC=4, COUNTDOWN_SEC=3, ROUND_END_FRAMES=2, ROUNDS_TO_WIN=2; frame_tick held high):
- Reset then start for 1 cycle -> phase=1, round_rst high for exactly 1 cycle, countdown 3,2,1 for 4 cycles each, then phase=2 with play_en=1 at cycle 13.
- In FIGHT, pulse game_over2 -> next cycle phase=3, p1_wins=1, round_winner=01, play_en=0; after 2 ticks phase=1 with a round_rst pulse.
- Repeat a P1 round win -> p1_wins=2, phase=4, match_winner=01; further game_over and frame ticks leave all outputs unchanged.
- game_over1 and game_over2 asserted in the same cycle during FIGHT -> phase=3, round_winner=00, win counts unchanged, then back to COUNTDOWN.
- Assert reset mid-COUNTDOWN and mid-ROUND_END -> next cycle phase=0 and all outputs 0; start during FIGHT has no effect.
- With FOOTIES_ROUND_TIMER_EN, ROUND_TIME_SEC=2:
  - health1=3, health2=1 -> after 8 FIGHT ticks phase=3, p1_wins+1;
  - equal health -> draw;
  - game_over1 in the expiry cycle -> P2 wins the round.
